// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: memory-window defaults, fetch FSM states
// and the IF/ID pipeline register layout.
package mips_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] DEFAULT_IMEM_BASE = 32'h0000_3000;
    localparam logic [31:0] DEFAULT_IMEM_LAST = 32'h0000_4000;

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef enum logic {
        RUN,
        FAULT
    } fetch_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] ins;
        logic [31:0] pc;
        logic [31:0] pc4;
    } if_id_t;

    // Empty IF/ID slot: decode sees a NOP that is marked invalid.
    localparam if_id_t IF_ID_BUBBLE = '{valid: 1'b0, ins: NOP, pc: 32'h0, pc4: 32'h0};

endpackage

// File: rtl/pc_range_check.sv
// Combinational fetch-address legality check: word aligned and inside the
// instruction-memory window (unsigned, both bounds inclusive).
module pc_range_check
    import mips_pkg::*;
#(
    parameter logic [31:0] IMEM_BASE = DEFAULT_IMEM_BASE,
    parameter logic [31:0] IMEM_LAST = DEFAULT_IMEM_LAST
) (
    input  logic [31:0] pc,
    output logic        valid
);

    logic aligned;
    logic inWindow;

    assign aligned  = (pc[1:0] == 2'b00);
    assign inWindow = (pc >= IMEM_BASE) && (pc <= IMEM_LAST);
    assign valid    = aligned && inWindow;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, IF/ID capture, stall, redirect
// and out-of-window fault handling. Macro FETCH_DELAY_SLOT_EN keeps the
// delay-slot instruction on redirect; otherwise it is replaced by a bubble.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] IMEM_BASE = DEFAULT_IMEM_BASE,
    parameter logic [31:0] IMEM_LAST = DEFAULT_IMEM_LAST
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] ins_addr,
    input  logic [31:0] ins,
    output logic        if_id_valid,
    output logic [31:0] if_id_ins,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic        fetch_fault,
    output logic [31:0] fault_pc
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  faultPc_q, faultPc_d;
    if_id_t       ifId_q, ifId_d;

    logic         pcValid;
    logic [31:0]  pcPlus4;
    if_id_t       fetched;

    assign pcPlus4 = pc_q + 32'd4;
    assign fetched = '{valid: 1'b1, ins: ins, pc: pc_q, pc4: pcPlus4};

    pc_range_check #(
        .IMEM_BASE (IMEM_BASE),
        .IMEM_LAST (IMEM_LAST)
    ) uRangeCheck (
        .pc    (pc_q),
        .valid (pcValid)
    );

    // Stall has priority over everything, then the fault check, so a
    // redirect arriving with a bad PC is dropped and the fault is reported.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        faultPc_d = faultPc_q;
        ifId_d    = ifId_q;
        unique case (state_q)
            RUN: begin
                if (!stall) begin
                    if (!pcValid) begin
                        ifId_d    = IF_ID_BUBBLE;
                        faultPc_d = pc_q;
                        state_d   = FAULT;
                    end else if (redirect) begin
`ifdef FETCH_DELAY_SLOT_EN
                        ifId_d = fetched;
`else
                        ifId_d = IF_ID_BUBBLE;
`endif
                        pc_d   = redirect_pc;
                    end else begin
                        ifId_d = fetched;
                        pc_d   = pcPlus4;
                    end
                end
            end
            FAULT: begin
                ifId_d = IF_ID_BUBBLE;
                if (redirect && !stall) begin
                    pc_d    = redirect_pc;
                    state_d = RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            faultPc_q <= 32'h0;
            ifId_q    <= IF_ID_BUBBLE;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            faultPc_q <= faultPc_d;
            ifId_q    <= ifId_d;
        end
    end

    assign ins_addr    = pc_q;
    assign if_id_valid = ifId_q.valid;
    assign if_id_ins   = ifId_q.ins;
    assign if_id_pc    = ifId_q.pc;
    assign if_id_pc4   = ifId_q.pc4;
    assign fetch_fault = (state_q == FAULT);
    assign fault_pc    = faultPc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a rule-level reference model checked
// every cycle, plus directed vectors with hand-computed literal expectations.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] ins_addr;
    logic [31:0] ins;
    logic        if_id_valid;
    logic [31:0] if_id_ins;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic        fetch_fault;
    logic [31:0] fault_pc;

    int checks;
    int failures;

`ifdef FETCH_DELAY_SLOT_EN
    localparam bit DELAY_SLOT = 1'b1;
`else
    localparam bit DELAY_SLOT = 1'b0;
`endif

    fetch_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ins_addr    (ins_addr),
        .ins         (ins),
        .if_id_valid (if_id_valid),
        .if_id_ins   (if_id_ins),
        .if_id_pc    (if_id_pc),
        .if_id_pc4   (if_id_pc4),
        .fetch_fault (fetch_fault),
        .fault_pc    (fault_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: a word pattern that depends on its address.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign ins = memWord(ins_addr);

    // Reference model written straight from the fetch rules.
    logic [31:0] mPc;
    bit          mFaulted;
    logic [31:0] mFaultPc;
    bit          mValid;
    logic [31:0] mIns;
    logic [31:0] mIfPc;
    logic [31:0] mIfPc4;

    function automatic bit legalPc(input logic [31:0] a);
        return (a % 4 == 0) && (a >= 32'h3000) && (a <= 32'h4000);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mPc = 32'h3000; mFaulted = 0; mFaultPc = 0;
            mValid = 0; mIns = 0; mIfPc = 0; mIfPc4 = 0;
        end else if (mFaulted) begin
            mValid = 0; mIns = 0; mIfPc = 0; mIfPc4 = 0;
            if (redirect && !stall) begin
                mPc = redirect_pc;
                mFaulted = 0;
            end
        end else if (!stall) begin
            if (!legalPc(mPc)) begin
                mValid = 0; mIns = 0; mIfPc = 0; mIfPc4 = 0;
                mFaultPc = mPc;
                mFaulted = 1;
            end else begin
                mValid = 1; mIns = memWord(mPc); mIfPc = mPc; mIfPc4 = mPc + 32'd4;
                if (redirect) begin
                    if (!DELAY_SLOT) begin
                        mValid = 0; mIns = 0; mIfPc = 0; mIfPc4 = 0;
                    end
                    mPc = redirect_pc;
                end else begin
                    mPc = mPc + 32'd4;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every negedge the DUT must agree with the model.
    always @(negedge clk) begin
        checkOutput("m.ins_addr",    ins_addr,             mPc);
        checkOutput("m.if_id_valid", {31'b0, if_id_valid}, {31'b0, mValid});
        checkOutput("m.if_id_ins",   if_id_ins,            mIns);
        checkOutput("m.if_id_pc",    if_id_pc,             mIfPc);
        checkOutput("m.if_id_pc4",   if_id_pc4,            mIfPc4);
        checkOutput("m.fetch_fault", {31'b0, fetch_fault}, {31'b0, mFaulted});
        checkOutput("m.fault_pc",    fault_pc,             mFaultPc);
    end

    // Drive one cycle's inputs, then settle just after the capturing edge.
    task automatic applyStimulus(input bit s, input bit r, input logic [31:0] rpc);
        stall = s;
        redirect = r;
        redirect_pc = rpc;
        @(posedge clk);
        #1;
    endtask

    task automatic expectIfId(input string tag, input bit v, input logic [31:0] pc);
        checkOutput({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, v});
        checkOutput({tag, ".pc"},    if_id_pc,             pc);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst.ins_addr", ins_addr, 32'h3000);
        checkOutput("rst.valid", {31'b0, if_id_valid}, 32'h0);
        checkOutput("rst.fault", {31'b0, fetch_fault}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential fetch from reset.
        applyStimulus(0, 0, 0);
        expectIfId("run0", 1, 32'h3000);
        checkOutput("run0.pc4", if_id_pc4, 32'h3004);
        checkOutput("run0.ins", if_id_ins, memWord(32'h3000));
        applyStimulus(0, 0, 0);
        expectIfId("run1", 1, 32'h3004);

        // Stall three cycles at pc=3008.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 0);
            checkOutput("stall.addr", ins_addr, 32'h3008);
            expectIfId("stall", 1, 32'h3004);
        end
        applyStimulus(0, 0, 0);
        expectIfId("resume", 1, 32'h3008);
        applyStimulus(0, 0, 0);
        checkOutput("pre_redir.addr", ins_addr, 32'h3010);

        // Redirect at 3010 to 3100.
        applyStimulus(0, 1, 32'h3100);
        expectIfId("dslot", DELAY_SLOT, DELAY_SLOT ? 32'h3010 : 32'h0);
        applyStimulus(0, 0, 0);
        expectIfId("target", 1, 32'h3100);

        // Redirect together with stall is ignored, then taken.
        applyStimulus(1, 1, 32'h3200);
        checkOutput("stallredir.addr", ins_addr, 32'h3104);
        expectIfId("stallredir", 1, 32'h3100);
        applyStimulus(0, 1, 32'h3200);
        checkOutput("redir2.addr", ins_addr, 32'h3200);
        applyStimulus(0, 0, 0);
        expectIfId("target2", 1, 32'h3200);

        // Out-of-window fault and recovery.
        applyStimulus(0, 1, 32'h4004);
        applyStimulus(0, 0, 0);
        checkOutput("fault.flag", {31'b0, fetch_fault}, 32'h1);
        checkOutput("fault.pc", fault_pc, 32'h4004);
        expectIfId("fault", 0, 32'h0);
        applyStimulus(1, 0, 0);
        checkOutput("fault.stall", {31'b0, fetch_fault}, 32'h1);
        applyStimulus(0, 1, 32'h3000);
        checkOutput("recover.flag", {31'b0, fetch_fault}, 32'h0);
        expectIfId("recover", 0, 32'h0);
        applyStimulus(0, 0, 0);
        expectIfId("recover1", 1, 32'h3000);

        // Misaligned target; a redirect in the faulting cycle is dropped.
        applyStimulus(0, 1, 32'h3002);
        applyStimulus(0, 1, 32'h3100);
        checkOutput("mis.flag", {31'b0, fetch_fault}, 32'h1);
        checkOutput("mis.pc", fault_pc, 32'h3002);
        checkOutput("mis.addr", ins_addr, 32'h3002);
        applyStimulus(0, 1, 32'h3000);
        applyStimulus(0, 0, 0);
        expectIfId("mis.recover", 1, 32'h3000);

        // Window edges: 4000 is legal, the next word and 2FFC are not.
        applyStimulus(0, 1, 32'h4000);
        applyStimulus(0, 0, 0);
        expectIfId("last", 1, 32'h4000);
        applyStimulus(0, 0, 0);
        checkOutput("pastlast.pc", fault_pc, 32'h4004);
        applyStimulus(0, 1, 32'h2FFC);
        applyStimulus(0, 0, 0);
        checkOutput("below.pc", fault_pc, 32'h2FFC);
        checkOutput("below.flag", {31'b0, fetch_fault}, 32'h1);

        // Asynchronous reset while faulted.
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst.fault", {31'b0, fetch_fault}, 32'h0);
        checkOutput("arst.faultpc", fault_pc, 32'h0);
        checkOutput("arst.addr", ins_addr, 32'h3000);
        checkOutput("arst.valid", {31'b0, if_id_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0);
        expectIfId("arst.run", 1, 32'h3000);
        applyStimulus(0, 0, 0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
